// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load formats, syscall codes
// and the syscall FSM state encoding.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  localparam logic [31:0] SYS_PRINT = 32'd1;
  localparam logic [31:0] SYS_EXIT  = 32'd10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } sys_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load formatter: picks the addressed byte/halfword out of the
// raw memory word and sign- or zero-extends it.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = rdata_i[{offset_i, 3'b000} +: 8];
    half_s = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (load_type_i)
      LT_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      LT_LBU:  data_o = {24'd0, byte_s};
      LT_LH:   data_o = {{16{half_s[15]}}, half_s};
      LT_LHU:  data_o = {16'd0, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, result select, register-file write port drive,
// syscall retirement (print/exit) and retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [31:0]           in_pc,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [31:0]           in_mem_rdata,
  input  logic [4:0]            in_waddr,
  input  logic                  in_regwrite,
  input  logic                  in_memtoreg,
  input  logic                  in_link,
  input  logic [2:0]            in_load_type,
  input  logic                  in_syscall,
  input  logic [DATA_WIDTH-1:0] v0_data,
  input  logic [DATA_WIDTH-1:0] a0_data,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_valid,
  output logic [31:0]           wb_pc,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic [31:0]           retired
);

  logic                  valid_q, valid_d;
  logic [31:0]           pc_q, pc_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [4:0]            waddr_q, waddr_d;
  logic                  regwrite_q, regwrite_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  link_q, link_d;
  logic [2:0]            load_type_q, load_type_d;
  logic                  syscall_q, syscall_d;
  logic                  done_q, done_d;
  sys_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] disp_q, disp_d;
  logic [31:0]           retired_q, retired_d;

  logic        capture_s;
  logic        flush_take_s;
  logic        sys_fire_s;
  logic [31:0] load_data_s;

  wb_stage_load_align u_load_align (
    .rdata_i     (rdata_q),
    .offset_i    (alu_q[1:0]),
    .load_type_i (load_type_q),
    .data_o      (load_data_s)
  );

  // Pipeline register next state: halt freezes, flush beats stall.
  always_comb begin
    capture_s    = ~halted & ~flush & ~stall;
    flush_take_s = ~halted & flush;
    valid_d      = valid_q;
    pc_d         = pc_q;
    alu_d        = alu_q;
    rdata_d      = rdata_q;
    waddr_d      = waddr_q;
    regwrite_d   = regwrite_q;
    memtoreg_d   = memtoreg_q;
    link_d       = link_q;
    load_type_d  = load_type_q;
    syscall_d    = syscall_q;
    retired_d    = retired_q;
    if (capture_s) begin
      valid_d     = in_valid;
      pc_d        = in_pc;
      alu_d       = in_alu_result;
      rdata_d     = in_mem_rdata;
      waddr_d     = in_waddr;
      regwrite_d  = in_regwrite;
      memtoreg_d  = in_memtoreg;
      link_d      = in_link;
      load_type_d = in_load_type;
      syscall_d   = in_syscall;
      retired_d   = in_valid ? retired_q + 32'd1 : retired_q;
    end else if (flush_take_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Syscall FSM; done_q keeps a stalled syscall from firing twice.
  always_comb begin
    sys_fire_s = (state_q == ST_RUN) & valid_q & syscall_q & ~done_q;
    state_d    = state_q;
    disp_d     = disp_q;
    case (state_q)
      ST_RUN: begin
        if (sys_fire_s && v0_data == DATA_WIDTH'(SYS_EXIT)) begin
          state_d = ST_HALT;
        end else if (sys_fire_s && v0_data == DATA_WIDTH'(SYS_PRINT)) begin
          disp_d = a0_data;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
    if (capture_s || flush_take_s) begin
      done_d = 1'b0;
    end else if (sys_fire_s) begin
      done_d = 1'b1;
    end else begin
      done_d = done_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'd0;
      alu_q       <= '0;
      rdata_q     <= 32'd0;
      waddr_q     <= 5'd0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      link_q      <= 1'b0;
      load_type_q <= 3'd0;
      syscall_q   <= 1'b0;
      done_q      <= 1'b0;
      state_q     <= ST_RUN;
      disp_q      <= '0;
      retired_q   <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      waddr_q     <= waddr_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      link_q      <= link_d;
      load_type_q <= load_type_d;
      syscall_q   <= syscall_d;
      done_q      <= done_d;
      state_q     <= state_d;
      disp_q      <= disp_d;
      retired_q   <= retired_d;
    end
  end

  // Write-port drive straight from the registered fields.
  always_comb begin
    if (link_q) begin
      rf_wdata = DATA_WIDTH'(pc_q + 32'd4);
    end else if (memtoreg_q) begin
      rf_wdata = DATA_WIDTH'(load_data_s);
    end else begin
      rf_wdata = alu_q;
    end
    rf_we    = valid_q & regwrite_q & (waddr_q != 5'd0) & ~halted;
    rf_waddr = waddr_q;
  end

  assign halted    = (state_q == ST_HALT);
  assign wb_valid  = valid_q;
  assign wb_pc     = pc_q;
  assign disp_data = disp_q;
  assign retired   = retired_q;

endmodule
